// File: rtl/alu_byte_sequencer_pkg.sv
// Shared constants for the byte-serial ALU sequencer: FSM state codes,
// the ALU opcodes used around it, and the byte-counter width helper.
package alu_byte_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] ALU_SEL_ADD = 4'h0;
    localparam logic [3:0] ALU_SEL_AND = 4'h1;
    localparam logic [3:0] ALU_SEL_OR  = 4'h2;
    localparam logic [3:0] ALU_SEL_XOR = 4'h3;

    // Byte index width; a single-byte build still needs a 1-bit counter.
    function automatic int kw_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Request and response handshakes of the ALU byte sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface alu_byte_sequencer_if #(
    parameter int NBYTES = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_a;
    logic [8*NBYTES-1:0]   in_b;
    logic [3:0]            in_sel;
    logic                  in_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_result;
    logic                  out_cout;
    logic                  out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_cin, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_cin, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_zero
    );
endinterface

// File: rtl/alu_byte_sequencer.sv
// Drives an external 8-bit ALU one byte per cycle (LSB first), chaining its
// carry-out into the next byte and assembling the wide result and flags.
module alu_byte_sequencer
    import alu_byte_sequencer_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_byte_sequencer_if.slave  bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_sel,
    output logic                 alu_cin,
    input  logic [7:0]           alu_s,
    input  logic                 alu_cout
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = kw_bits(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]    sel_q, sel_d;
    logic          cin_q, cin_d, carry_q, carry_d, cout_q, cout_d, zero_q, zero_d;

    logic [7:0]    a_byte [NBYTES];
    logic [7:0]    b_byte [NBYTES];
    logic [W-1:0]  result_merged;
    logic          exec;

    // result_merged is the result register with byte k replaced by the live ALU output,
    // so the zero flag can be taken from the complete result on the last byte.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign a_byte[gi] = a_q[gi*8 +: 8];
            assign b_byte[gi] = b_q[gi*8 +: 8];
            assign result_merged[gi*8 +: 8] = (k_q == KW'(gi)) ? alu_s : result_q[gi*8 +: 8];
        end
    endgenerate

    assign exec           = (state_q == ST_EXEC);
    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_cout   = cout_q;
    assign bus.out_zero   = zero_q;

    assign alu_a   = exec ? a_byte[k_q] : 8'h00;
    assign alu_b   = exec ? b_byte[k_q] : 8'h00;
    assign alu_sel = sel_q;
    assign alu_cin = exec ? ((k_q == '0) ? cin_q : carry_q) : 1'b0;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    sel_d   = bus.in_sel;
                    cin_d   = bus.in_cin;
                    k_d     = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = result_merged;
                carry_d  = alu_cout;
                if (k_q == K_LAST) begin
                    cout_d  = alu_cout;
                    zero_d  = ~|result_merged;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

endmodule
